// File: rtl/hamming_dec.sv
// rtl/hamming_dec.sv - Hamming(21,16) single-error-correcting decoder with valid/ready handshakes
// Codeword bit i is position i+1; parity at positions 1,2,4,8,16.
module hamming_dec #(
  parameter bit CORRECT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [20:0] iData,
  input  logic        iValid,
  output logic        oReady,
  output logic [15:0] oData,
  output logic [1:0]  oErr,
  output logic [4:0]  oSyn,
  output logic        oValid,
  input  logic        iReady
);

  typedef enum logic [1:0] {IDLE, SYND, CORR, HOLD} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [20:0] cw;
  logic [4:0]  syn;
  logic [4:0]  syn_c;
  logic [20:0] cw_fix;
  logic [1:0]  err_c;
  logic [15:0] data_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (iValid) state_nxt = SYND;
      SYND:    state_nxt = CORR;
      CORR:    state_nxt = HOLD;
      HOLD:    if (iReady) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign oReady = (state == IDLE);

  // Syndrome bit k covers every position whose index has bit k set.
  always_comb begin
    syn_c = '0;
    for (int p = 1; p <= 21; p++) begin
      for (int k = 0; k < 5; k++) begin
        if (((p >> k) & 1) == 1) syn_c[k] = syn_c[k] ^ cw[p-1];
      end
    end
  end

  always_comb begin
    cw_fix = cw;
    err_c  = 2'b00;
    if (syn != 5'd0 && syn <= 5'd21) begin
      err_c = 2'b01;
      if (CORRECT) cw_fix[syn - 5'd1] = ~cw[syn - 5'd1];
    end else if (syn != 5'd0) begin
      err_c = 2'b10;
    end
    data_c = {cw_fix[20:16], cw_fix[14:8], cw_fix[6:4], cw_fix[2]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cw     <= '0;
      syn    <= '0;
      oData  <= '0;
      oErr   <= '0;
      oSyn   <= '0;
      oValid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (iValid) cw <= iData;
        SYND: syn <= syn_c;
        CORR: begin
          oData  <= data_c;
          oErr   <= err_c;
          oSyn   <= syn;
          oValid <= 1'b1;
        end
        HOLD: if (iReady) oValid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_dec.sv
// tb/tb_hamming_dec.sv - directed and loopback checks for hamming_dec
// Runs a correcting and a detect-only decoder side by side on the same stimulus.
`timescale 1ns/1ps
module tb_hamming_dec;

  logic        clk;
  logic        rst;
  logic [20:0] iData;
  logic        iValid;
  logic        iReady;
  logic        oReady,  oValid;
  logic [15:0] oData;
  logic [1:0]  oErr;
  logic [4:0]  oSyn;
  logic        nc_ready, nc_valid;
  logic [15:0] nc_data;
  logic [1:0]  nc_err;
  logic [4:0]  nc_syn;

  int n_cmp = 0;
  int n_bad = 0;

  hamming_dec #(.CORRECT(1'b1)) dut (
    .clk(clk), .rst(rst), .iData(iData), .iValid(iValid), .oReady(oReady),
    .oData(oData), .oErr(oErr), .oSyn(oSyn), .oValid(oValid), .iReady(iReady)
  );

  hamming_dec #(.CORRECT(1'b0)) dut_nc (
    .clk(clk), .rst(rst), .iData(iData), .iValid(iValid), .oReady(nc_ready),
    .oData(nc_data), .oErr(nc_err), .oSyn(nc_syn), .oValid(nc_valid), .iReady(iReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [20:0] enc(input logic [15:0] d);
    logic [20:0] c;
    c = '0;
    c[2]     = d[0];
    c[6:4]   = d[3:1];
    c[14:8]  = d[10:4];
    c[20:16] = d[15:11];
    for (int k = 0; k < 5; k++) begin
      logic par;
      par = 1'b0;
      for (int p = 1; p <= 21; p++)
        if (((p >> k) & 1) == 1) par = par ^ c[p-1];
      c[(1 << k) - 1] = par;
    end
    return c;
  endfunction

  function automatic logic [15:0] extract(input logic [20:0] c);
    return {c[20:16], c[14:8], c[6:4], c[2]};
  endfunction

  task automatic send(input logic [20:0] word);
    int n;
    n = 0;
    while (!oReady && n < 20) begin @(posedge clk); #1; n++; end
    check_val("accept_ready", {31'd0, oReady}, 32'd1);
    iData  = word;
    iValid = 1'b1;
    @(posedge clk); #1;
    iValid = 1'b0;
    iData  = 21'($urandom);
  endtask

  task automatic wait_out(input string tag, output int n);
    n = 0;
    while (!oValid && n < 20) begin @(posedge clk); #1; n++; end
    check_val({tag, ".lat"}, n, 2);
  endtask

  task automatic run_word(input string tag, input logic [20:0] word, input logic [15:0] exp_d,
                          input logic [1:0] exp_e, input logic [4:0] exp_s, input logic [15:0] exp_nc);
    int n;
    send(word);
    wait_out(tag, n);
    check_val({tag, ".data"}, {16'd0, oData}, {16'd0, exp_d});
    check_val({tag, ".err"},  {30'd0, oErr},  {30'd0, exp_e});
    check_val({tag, ".syn"},  {27'd0, oSyn},  {27'd0, exp_s});
    check_val({tag, ".nc_data"}, {16'd0, nc_data}, {16'd0, exp_nc});
    check_val({tag, ".nc_err"},  {30'd0, nc_err},  {30'd0, exp_e});
    check_val({tag, ".nc_syn"},  {27'd0, nc_syn},  {27'd0, exp_s});
    iReady = 1'b1;
    @(posedge clk); #1;
    iReady = 1'b0;
    check_val({tag, ".drop"}, {31'd0, oValid}, 32'd0);
  endtask

  initial begin
    int n;
    logic [15:0] d;
    logic [20:0] c, bad;
    int pos;

    rst = 1'b0; iData = '0; iValid = 1'b0; iReady = 1'b0;
    #12;
    check_val("rst.ready", {31'd0, oReady}, 32'd1);
    check_val("rst.valid", {31'd0, oValid}, 32'd0);
    check_val("rst.data",  {16'd0, oData},  32'd0);
    check_val("rst.err",   {30'd0, oErr},   32'd0);
    check_val("rst.syn",   {27'd0, oSyn},   32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    run_word("t1", 21'h000000, 16'h0000, 2'b00, 5'd0,  16'h0000);
    run_word("t2", 21'h000010, 16'h0000, 2'b01, 5'd5,  16'h0002);
    run_word("t3", 21'h008000, 16'h0000, 2'b01, 5'd16, 16'h0000);
    run_word("t4", 21'h100004, 16'h8001, 2'b10, 5'd22, 16'h8001);
    run_word("enc", enc(16'hBEEF), 16'hBEEF, 2'b00, 5'd0, 16'hBEEF);

    // Backpressure with ignored iValid pulses while the result is held.
    send(enc(16'hA5C3) ^ 21'h000200);
    wait_out("bp", n);
    for (int i = 0; i < 50; i++) begin
      iValid = i[0];
      iData  = 21'($urandom);
      @(posedge clk); #1;
      check_val("bp.valid", {31'd0, oValid}, 32'd1);
      check_val("bp.data",  {16'd0, oData},  {16'd0, 16'hA5C3});
      check_val("bp.ready", {31'd0, oReady}, 32'd0);
    end
    iValid = 1'b0;
    check_val("bp.syn", {27'd0, oSyn}, 32'd10);
    iReady = 1'b1;
    @(posedge clk); #1;
    iReady = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check_val("bp.once", {31'd0, oValid}, 32'd0);
      @(posedge clk); #1;
    end

    // iReady already high before the result appears: exactly one delivery cycle.
    iReady = 1'b1;
    send(enc(16'h1234));
    wait_out("rdy", n);
    check_val("rdy.data", {16'd0, oData}, {16'd0, 16'h1234});
    @(posedge clk); #1;
    check_val("rdy.drop", {31'd0, oValid}, 32'd0);
    iReady = 1'b0;

    for (int i = 0; i < 20; i++) begin
      d   = 16'($urandom);
      pos = int'($urandom_range(0, 20));
      c   = enc(d);
      bad = c;
      bad[pos] = ~bad[pos];
      run_word("loop", bad, d, 2'b01, 5'(pos + 1), extract(bad));
    end

    // Reset while the word sits in SYND: discarded, never emitted.
    send(enc(16'hCAFE));
    rst = 1'b0;
    #1;
    check_val("mid.valid", {31'd0, oValid}, 32'd0);
    check_val("mid.ready", {31'd0, oReady}, 32'd1);
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check_val("mid.none", {31'd0, oValid}, 32'd0);
    end
    run_word("post", enc(16'h0F0F), 16'h0F0F, 2'b00, 5'd0, 16'h0F0F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
